// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the MAC stream datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mac_pkg;

    // Data lane width of the vector stream.
    localparam int LANE_W = 32;

    // Default geometry: beats per pass, passes per run, MAC lanes.
    localparam int DEF_J = 14;
    localparam int DEF_I = 7;
    localparam int DEF_A = 2;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT,
        DONE
    } feeder_state_t;

    // Counter width able to hold the value n itself, not just 0..n-1.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/feeder_ctrl.sv
// Run sequencer: FSM plus beat (k) and pass counters, emits read addresses and strobes.
// Latency: strobes/addresses are combinational from state; STREAM entered 1 edge after start/beta.
// Backpressure: none on the stream; between passes it stalls in WAIT until beta_tvalid.
module feeder_ctrl
    import mac_pkg::*;
#(
    parameter int J = DEF_J,
    parameter int I = DEF_I,
    localparam int J_WIDTH = cnt_width(J),
    localparam int I_WIDTH = cnt_width(I),
    localparam int M_WIDTH = cnt_width(I * J)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               beta_tvalid,
    output logic               idle,
    output logic               in_done,
    output logic               beat_vld,
    output logic               beat_last,
    output logic [J_WIDTH-1:0] beat_idx,
    output logic [M_WIDTH-1:0] mat_addr,
    output logic [I_WIDTH-1:0] pass_cnt
);

    feeder_state_t      state, state_nxt;
    logic [J_WIDTH-1:0] k, k_nxt;
    logic [I_WIDTH-1:0] pass, pass_nxt;
    logic               k_at_end;

    assign k_at_end = (k == J_WIDTH'(J - 1));

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            pass  <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            pass  <= pass_nxt;
        end
    end

    // Next-state and counter update; k only restarts by explicit clear.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        pass_nxt  = pass;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = STREAM;
                    k_nxt     = '0;
                    pass_nxt  = '0;
                end
            end
            STREAM: begin
                if (k_at_end) begin
                    state_nxt = WAIT;
                end else begin
                    k_nxt = k + J_WIDTH'(1);
                end
            end
            WAIT: begin
                if (beta_tvalid) begin
                    if (pass < I_WIDTH'(I - 1)) begin
                        pass_nxt  = pass + I_WIDTH'(1);
                        k_nxt     = '0;
                        state_nxt = STREAM;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign idle      = (state == IDLE);
    assign in_done   = (state == DONE);
    assign beat_vld  = (state == STREAM);
    assign beat_last = (state == STREAM) && k_at_end;
    assign beat_idx  = k;
    assign pass_cnt  = pass;
    // Full-width bank offset: largest address (I-1)*J + J-1 fits M_WIDTH.
    assign mat_addr  = M_WIDTH'(pass) * M_WIDTH'(J) + M_WIDTH'(k);

endmodule

// File: rtl/mac_stream_feeder.sv
// Vector/mask store that streams I passes of J beats into the MAC on start.
// Latency: beat 0 valid 2 edges after start (or after beta_tvalid); all outputs registered.
// Backpressure: streams have no ready; the next pass is held off until beta_tvalid.
module mac_stream_feeder
    import mac_pkg::*;
#(
    parameter int J = DEF_J,
    parameter int I = DEF_I,
    parameter int A = DEF_A,
    localparam int J_WIDTH = cnt_width(J),
    localparam int I_WIDTH = cnt_width(I),
    localparam int M_WIDTH = cnt_width(I * J)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vec_wr_en,
    input  logic [J_WIDTH-1:0] vec_wr_addr,
    input  logic [LANE_W-1:0]  vec_wr_data,
    input  logic               mat_wr_en,
    input  logic [M_WIDTH-1:0] mat_wr_addr,
    input  logic [A-1:0]       mat_wr_data,
    input  logic               start,
    input  logic               beta_tvalid,
    output logic [LANE_W-1:0]  vinput,
    output logic               vinput_tvalid,
    output logic               vinput_tlast,
    output logic [A-1:0]       M_row,
    output logic               M_row_tvalid,
    output logic               M_row_tlast,
    output logic [I_WIDTH-1:0] pass_idx,
    output logic               busy,
    output logic               done
);

    localparam int J_AW = $clog2(J);
    localparam int M_AW = $clog2(I * J);

    // Storage is deliberately not reset so a run can be repeated after rst.
    logic [LANE_W-1:0] vec [J];
    logic [A-1:0]      mat [I*J];

    logic               idle, in_done, beat_vld, beat_last;
    logic [J_WIDTH-1:0] beat_idx;
    logic [M_WIDTH-1:0] mat_addr;
    logic [I_WIDTH-1:0] pass_cnt;

    logic [LANE_W-1:0]  vinput_q;
    logic [A-1:0]       m_row_q;
    logic               strm_vld_q, strm_last_q;
    logic [I_WIDTH-1:0] pass_q;
    logic               busy_q, done_q;
    logic               wr_ok;
    logic [LANE_W-1:0]  vec_rd;
    logic [A-1:0]       mat_rd;

    feeder_ctrl #(
        .J (J),
        .I (I)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .beta_tvalid (beta_tvalid),
        .idle        (idle),
        .in_done     (in_done),
        .beat_vld    (beat_vld),
        .beat_last   (beat_last),
        .beat_idx    (beat_idx),
        .mat_addr    (mat_addr),
        .pass_cnt    (pass_cnt)
    );

    // Host writes land only when the sequencer is idle and busy has dropped.
    assign wr_ok = idle && !busy_q;

    // Host write port; out-of-range addresses are discarded.
    always_ff @(posedge clk) begin
        if (wr_ok && vec_wr_en && (vec_wr_addr < J_WIDTH'(J))) begin
            vec[vec_wr_addr[J_AW-1:0]] <= vec_wr_data;
        end
        if (wr_ok && mat_wr_en && (mat_wr_addr < M_WIDTH'(I * J))) begin
            mat[mat_wr_addr[M_AW-1:0]] <= mat_wr_data;
        end
    end

    // Combinational storage read at the sequencer's addresses, guarded to the array bounds.
    always_comb begin
        vec_rd = '0;
        mat_rd = '0;
        if (beat_idx < J_WIDTH'(J)) begin
            vec_rd = vec[beat_idx[J_AW-1:0]];
        end
        if (mat_addr < M_WIDTH'(I * J)) begin
            mat_rd = mat[mat_addr[M_AW-1:0]];
        end
    end

    // Output register stage; data holds its last beat while the stream is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vinput_q    <= '0;
            m_row_q     <= '0;
            strm_vld_q  <= 1'b0;
            strm_last_q <= 1'b0;
            pass_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            strm_vld_q  <= beat_vld;
            strm_last_q <= beat_last;
            if (beat_vld) begin
                vinput_q <= vec_rd;
                m_row_q  <= mat_rd;
            end
            pass_q <= pass_cnt;
            busy_q <= !idle;
            done_q <= in_done;
        end
    end

    // One valid register and one last register feed both streams.
    assign vinput        = vinput_q;
    assign M_row         = m_row_q;
    assign vinput_tvalid = strm_vld_q;
    assign M_row_tvalid  = strm_vld_q;
    assign vinput_tlast  = strm_last_q;
    assign M_row_tlast   = strm_last_q;
    assign pass_idx      = pass_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_mac_stream_feeder.sv
// Self-checking bench for mac_stream_feeder: table-driven passes, random loads, hand corner cases.
// Latency: checks 2-edge start/beta-to-beat latency and done/busy timing.
// Backpressure: exercises long WAIT stalls and ignored beta/start pulses.
module tb_mac_stream_feeder;

    localparam int J  = 14;
    localparam int I  = 7;
    localparam int A  = 2;
    localparam int JW = 5;
    localparam int IW = 4;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vec_wr_en = 1'b0;
    logic [JW-1:0] vec_wr_addr = '0;
    logic [31:0]   vec_wr_data = '0;
    logic          mat_wr_en = 1'b0;
    logic [MW-1:0] mat_wr_addr = '0;
    logic [A-1:0]  mat_wr_data = '0;
    logic          start = 1'b0;
    logic          beta_tvalid = 1'b0;
    logic [31:0]   vinput;
    logic          vinput_tvalid, vinput_tlast;
    logic [A-1:0]  M_row;
    logic          M_row_tvalid, M_row_tlast;
    logic [IW-1:0] pass_idx;
    logic          busy, done;

    mac_stream_feeder dut (
        .clk           (clk),
        .rst           (rst),
        .vec_wr_en     (vec_wr_en),
        .vec_wr_addr   (vec_wr_addr),
        .vec_wr_data   (vec_wr_data),
        .mat_wr_en     (mat_wr_en),
        .mat_wr_addr   (mat_wr_addr),
        .mat_wr_data   (mat_wr_data),
        .start         (start),
        .beta_tvalid   (beta_tvalid),
        .vinput        (vinput),
        .vinput_tvalid (vinput_tvalid),
        .vinput_tlast  (vinput_tlast),
        .M_row         (M_row),
        .M_row_tvalid  (M_row_tvalid),
        .M_row_tlast   (M_row_tlast),
        .pass_idx      (pass_idx),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit in_run = 0;

    // Reference storage: what the DUT arrays should contain.
    logic [31:0]  vm [J];
    logic [A-1:0] mm [I*J];

    // Per-pass vector: beta delay after tlast (input) and cycles from tlast to next event (expected).
    typedef struct {
        int delay;
        int gap;
    } pass_vec_t;
    pass_vec_t tab [I];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wr_vec(input int addr, input logic [31:0] d);
        vec_wr_en = 1'b1;
        vec_wr_addr = JW'(addr);
        vec_wr_data = d;
        tick();
        vec_wr_en = 1'b0;
        if (!in_run && addr < J) vm[addr] = d;
    endtask

    task automatic wr_mat(input int addr, input logic [A-1:0] d);
        mat_wr_en = 1'b1;
        mat_wr_addr = MW'(addr);
        mat_wr_data = d;
        tick();
        mat_wr_en = 1'b0;
        if (!in_run && addr < I * J) mm[addr] = d;
    endtask

    function automatic logic [63:0] beat_exp(input int p, input int k);
        logic last;
        last = (k == J - 1);
        return 64'({1'b1, 1'b1, last, last, vm[k], mm[p*J+k], IW'(p)});
    endfunction

    function automatic logic [63:0] beat_act();
        return 64'({vinput_tvalid, M_row_tvalid, vinput_tlast, M_row_tlast, vinput, M_row, pass_idx});
    endfunction

    function automatic logic [63:0] reset_act();
        return 64'({vinput, M_row, vinput_tvalid, vinput_tlast, M_row_tvalid, M_row_tlast,
                    pass_idx, busy, done});
    endfunction

    task automatic expect_beat(input int p, input int k);
        chk($sformatf("beat_p%0d_k%0d", p, k), beat_act(), beat_exp(p, k));
        tick();
    endtask

    task automatic wait_idle(input int p);
        chk($sformatf("wait_p%0d", p), 64'({vinput_tvalid, M_row_tvalid, busy, pass_idx}),
            64'({1'b0, 1'b0, 1'b1, IW'(p)}));
    endtask

    // Leaves the bench in the tlast cycle of pass p.
    task automatic stream_pass(input int p);
        for (int k = 0; k < J - 1; k++) expect_beat(p, k);
        chk($sformatf("beat_p%0d_k%0d", p, J - 1), beat_act(), beat_exp(p, J - 1));
    endtask

    task automatic start_run();
        start = 1'b1;
        in_run = 1;
        tick();
        start = 1'b0;
        chk("start_lat", 64'({vinput_tvalid, M_row_tvalid, busy}), 64'(3'b000));
        tick();
    endtask

    // Called in the tlast cycle; pulses beta d cycles later and measures the gap to the next event.
    task automatic answer_beta(input int d, input int gap_exp, input int p, input bit last);
        int gap = 0;
        for (int i = 0; i < d; i++) begin
            if (i > 0) wait_idle(p);
            tick();
            gap++;
        end
        if (d > 0) wait_idle(p);
        beta_tvalid = 1'b1;
        tick();
        beta_tvalid = 1'b0;
        gap++;
        while (!(last ? done : vinput_tvalid) && gap < d + 20) begin
            tick();
            gap++;
        end
        chk($sformatf("gap_p%0d", p), 64'(gap), 64'(gap_exp));
        if (last) begin
            chk("done_busy", 64'(busy), 64'(1));
            tick();
            chk("done_end", 64'({done, busy, pass_idx}), 64'({1'b0, 1'b0, IW'(I - 1)}));
            in_run = 0;
        end
    endtask

    task automatic run_table();
        start_run();
        for (int p = 0; p < I; p++) begin
            stream_pass(p);
            answer_beta(tab[p].delay, tab[p].gap, p, p == I - 1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Beat 0 of the next pass (or done) lands 2 edges after the beta cycle.
        tab[0] = '{3, 5};
        tab[1] = '{3, 5};
        tab[2] = '{0, 2};
        tab[3] = '{1, 3};
        tab[4] = '{5, 7};
        tab[5] = '{2, 4};
        tab[6] = '{3, 5};

        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_state", reset_act(), 64'(0));
        rst = 1'b0;

        // Base pattern: vec[k]=k+1, mat[p*J+k]=k[1:0].
        for (int k = 0; k < J; k++) wr_vec(k, 32'(k + 1));
        for (int p = 0; p < I; p++)
            for (int k = 0; k < J; k++) wr_mat(p * J + k, A'(k));
        run_table();

        // Random loads, including addresses one past the end.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) wr_vec($urandom_range(0, J), $urandom);
            else wr_mat($urandom_range(0, I * J), A'($urandom_range(0, 3)));
        end
        wr_vec(J - 1, 32'h1313_1313);
        wr_mat(I * J - 1, 2'd2);
        wr_vec(J, 32'hFFFF_FFFF);
        wr_mat(I * J, 2'd1);
        run_table();

        // Long stall in WAIT, then start and a write during STREAM, then rst mid pass 2.
        start_run();
        stream_pass(0);
        for (int c = 0; c < 50; c++) begin
            tick();
            wait_idle(0);
        end
        beta_tvalid = 1'b1;
        tick();
        beta_tvalid = 1'b0;
        chk("beta_lat", 64'({vinput_tvalid, M_row_tvalid}), 64'(0));
        tick();
        for (int k = 0; k < J - 1; k++) begin
            if (k == 4) begin
                start = 1'b1;
                vec_wr_en = 1'b1;
                vec_wr_addr = '0;
                vec_wr_data = 32'hDEAD_BEEF;
            end
            expect_beat(1, k);
            start = 1'b0;
            vec_wr_en = 1'b0;
        end
        chk("beat_p1_last", beat_act(), beat_exp(1, J - 1));
        answer_beta(2, 4, 1, 0);
        for (int k = 0; k < 5; k++) expect_beat(2, k);
        rst = 1'b1;
        expect_beat(2, 5);
        rst = 1'b0;
        in_run = 0;
        chk("midrun_reset", reset_act(), 64'(0));
        run_table();

        // Beta coinciding with the final STREAM cycle is ignored.
        start_run();
        for (int k = 0; k < J - 1; k++) begin
            if (k == J - 2) beta_tvalid = 1'b1;
            expect_beat(0, k);
            beta_tvalid = 1'b0;
        end
        chk("beat_p0_last", beat_act(), beat_exp(0, J - 1));
        for (int c = 0; c < 6; c++) begin
            tick();
            wait_idle(0);
        end
        answer_beta(0, 2, 0, 0);
        for (int p = 1; p < I; p++) begin
            stream_pass(p);
            answer_beta(1, 3, p, p == I - 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
